// File: rtl/sop_pkg.sv
// Shared types and constants for the f_sop vector sweeper.
// Golden table bit i is f = x&~y | y&z for {x,y,z} = i.
package sop_pkg;

    localparam int         VEC_W      = 3;
    localparam logic [7:0] SOP_GOLDEN = 8'hB8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Saturating increment for the 4-bit error counter; it must never wrap.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : (v + 4'd1);
    endfunction

endpackage

// File: rtl/sop_hold_timer.sv
// Per-vector hold counter: counts 0..HOLD_CYCLES-1 while running and
// flags the sample edge on its final count.
module sop_hold_timer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    // Next hold count: cleared on load, wraps to zero after the sample edge.
    always_comb begin
        hold_d = hold_q;
        if (load_i) begin
            hold_d = '0;
        end else if (run_i) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign expire_o = run_i && (hold_q == HOLD_LAST);

endmodule

// File: rtl/sop_vector_sweeper.sv
// Drives all eight {x,y,z} vectors into f_sop, checks its output against the
// golden table and reports an error count plus a per-vector mismatch mask.
module sop_vector_sweeper
    import sop_pkg::*;
#(
    parameter int         HOLD_CYCLES = 1,
    parameter int         NUM_PASSES  = 1,
    parameter logic [7:0] EXPECTED    = SOP_GOLDEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             f_in,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic [3:0]       err_count,
    output logic [7:0]       mismatch_vec
);

    localparam int                PASS_W    = $clog2(NUM_PASSES + 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = 3'd7;

    state_e             state_q;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   xyz_q;
    logic [PASS_W-1:0]  pass_q;
    logic [3:0]         err_q;
    logic [7:0]         mm_q;
    logic               busy_q;
    logic               done_q;
    logic               expire_s;
    logic               bad_s;

    sop_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q != DRIVE),
        .run_i   (state_q == DRIVE),
        .expire_o(expire_s)
    );

    assign bad_s = (f_in != EXPECTED[vec_q]);

    // Sweep FSM with vector/pass counters and the result checker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            xyz_q   <= '0;
            pass_q  <= '0;
            err_q   <= 4'd0;
            mm_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Results of the previous run stay visible until a new start.
                    if (start) begin
                        state_q <= DRIVE;
                        vec_q   <= '0;
                        xyz_q   <= '0;
                        pass_q  <= '0;
                        err_q   <= 4'd0;
                        mm_q    <= 8'd0;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (expire_s) begin
                        if (bad_s) begin
                            err_q       <= sat_inc4(err_q);
                            mm_q[vec_q] <= 1'b1;
                        end
                        if (vec_q != VEC_LAST) begin
                            vec_q <= vec_q + 3'd1;
                            xyz_q <= vec_q + 3'd1;
                        end else if (pass_q != PASS_LAST) begin
                            vec_q  <= '0;
                            xyz_q  <= '0;
                            pass_q <= pass_q + PASS_W'(1);
                        end else begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            xyz_q   <= '0;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    xyz_q   <= '0;
                end
            endcase
        end
    end

    assign x            = xyz_q[2];
    assign y            = xyz_q[1];
    assign z            = xyz_q[0];
    assign vec_idx      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_q;
    assign mismatch_vec = mm_q;

endmodule
